// File: rtl/input_buffer_sched_if.sv
// Buffer-side handshake between the input buffer and its sequencer.
// slave = sequencer view, master = buffer/stream view.
interface input_buffer_sched_if;
  logic i_wr_beat;
  logic i_wr_last;
  logic i_dat_valid;
  logic o_wr_allow;
  logic o_bank_swap;
  logic o_rd_en;

  modport slave (
    input  i_wr_beat, i_wr_last, i_dat_valid,
    output o_wr_allow, o_bank_swap, o_rd_en
  );

  modport master (
    output i_wr_beat, i_wr_last, i_dat_valid,
    input  o_wr_allow, o_bank_swap, o_rd_en
  );
endinterface

// File: rtl/input_buffer_sched.sv
// Ping-pong input buffer sequencer: tracks bank fills, swaps banks, bursts row reads per tile.
// Define IBUF_SCHED_PERF_EN to add the o_stall_cycles fill-wait counter output.
module input_buffer_sched #(
  parameter int DEPTH_LOG2 = 8,
  parameter int TILE_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [TILE_W-1:0]   i_num_tiles,
  input  logic [DEPTH_LOG2:0] i_rows,
  input  logic                i_core_ready,
  input_buffer_sched_if.slave ibuf,
  output logic                o_busy,
  output logic                o_done,
  output logic [TILE_W-1:0]   o_tile_idx,
  output logic                o_err
`ifdef IBUF_SCHED_PERF_EN
  ,
  output logic [31:0]         o_stall_cycles
`endif
);

  localparam int RW = DEPTH_LOG2 + 1;

  typedef enum logic [2:0] {IDLE, WAIT_FILL, SWAP, READ, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [TILE_W-1:0]   num_tiles_q;
  logic [RW-1:0]       rows_q;
  logic [RW-1:0]       row_cnt;
  logic [RW-1:0]       beat_cnt;
  logic [TILE_W-1:0]   tiles_filled;
  logic [1:0]          mod3;
  logic                wr_full;

  logic start_ok;
  logic pkt_end;
  logic drain_done;
  logic last_tile;

  assign start_ok   = i_start & ~i_abort & (state == IDLE);
  assign pkt_end    = ibuf.i_wr_beat & ibuf.i_wr_last;
  assign drain_done = (state == DRAIN) & (beat_cnt == rows_q) & ~ibuf.i_dat_valid;
  assign last_tile  = (o_tile_idx + TILE_W'(1)) == num_tiles_q;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt        = state;
    o_busy           = (state != IDLE);
    ibuf.o_bank_swap = (state == SWAP);
    ibuf.o_rd_en     = (state == READ);
    ibuf.o_wr_allow  = (state != IDLE) & ~wr_full & (tiles_filled < num_tiles_q);
    case (state)
      IDLE:      if (start_ok && i_num_tiles != '0) state_nxt = WAIT_FILL;
      WAIT_FILL: if (wr_full && i_core_ready)       state_nxt = SWAP;
      SWAP:      state_nxt = READ;
      READ:      if (row_cnt == rows_q - RW'(1))    state_nxt = DRAIN;
      DRAIN:     if (drain_done)                    state_nxt = last_tile ? IDLE : WAIT_FILL;
      default:   state_nxt = IDLE;
    endcase
    if (i_abort) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Job configuration and per-tile counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_tiles_q <= '0;
      rows_q      <= RW'(1);
      row_cnt     <= '0;
      beat_cnt    <= '0;
      o_tile_idx  <= '0;
      o_done      <= 1'b0;
    end else begin
      if (start_ok) begin
        num_tiles_q <= i_num_tiles;
        rows_q      <= (i_rows == '0) ? RW'(1) : i_rows;
      end

      if (state == READ) row_cnt <= row_cnt + RW'(1);
      else               row_cnt <= '0;

      if (state == SWAP)
        beat_cnt <= '0;
      else if ((state == READ || state == DRAIN) && ibuf.i_dat_valid)
        beat_cnt <= beat_cnt + RW'(1);

      if (start_ok)                     o_tile_idx <= '0;
      else if (drain_done && !i_abort)  o_tile_idx <= o_tile_idx + TILE_W'(1);

      o_done <= ~i_abort & ((start_ok & (i_num_tiles == '0)) | (drain_done & last_tile));
    end
  end

  // Write-side snoop: bank fill flag, packet count and 3-beat alignment for the 64->96 gearbox.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_full      <= 1'b0;
      tiles_filled <= '0;
      mod3         <= '0;
      o_err        <= 1'b0;
    end else begin
      if (i_abort)               wr_full <= 1'b0;
      else if (pkt_end)          wr_full <= 1'b1;
      else if (ibuf.o_bank_swap) wr_full <= 1'b0;

      if (start_ok)     tiles_filled <= '0;
      else if (pkt_end) tiles_filled <= tiles_filled + TILE_W'(1);

      if (start_ok || ibuf.o_bank_swap) mod3 <= '0;
      else if (ibuf.i_wr_beat)          mod3 <= (mod3 == 2'd2) ? 2'd0 : mod3 + 2'd1;

      // The last beat completes a multiple of 3 only if two beats were already pending.
      if (start_ok)                      o_err <= 1'b0;
      else if (pkt_end && mod3 != 2'd2)  o_err <= 1'b1;
    end
  end

`ifdef IBUF_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      o_stall_cycles <= '0;
    else if (start_ok)
      o_stall_cycles <= '0;
    else if (o_busy && state == WAIT_FILL && o_stall_cycles != '1)
      o_stall_cycles <= o_stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_input_buffer_sched.sv
// Scoreboard bench for input_buffer_sched: per-job and per-tile expectations are queued at start
// and retired by a negedge monitor; a 3-cycle delay line models the buffer read latency.
module tb_input_buffer_sched;
  localparam int DEPTH_LOG2 = 8;
  localparam int TILE_W     = 16;

  typedef struct {
    int tiles;
    int rows;
    bit err;
  } job_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                core_ready = 1'b1;
  logic [TILE_W-1:0]   num_tiles = '0;
  logic [DEPTH_LOG2:0] rows = '0;
  logic                busy, done, err;
  logic [TILE_W-1:0]   tile_idx;
`ifdef IBUF_SCHED_PERF_EN
  logic [31:0]         stall_cycles;
`endif

  input_buffer_sched_if bus();

  input_buffer_sched #(.DEPTH_LOG2(DEPTH_LOG2), .TILE_W(TILE_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_abort      (abort),
    .i_num_tiles  (num_tiles),
    .i_rows       (rows),
    .i_core_ready (core_ready),
    .ibuf         (bus),
    .o_busy       (busy),
    .o_done       (done),
    .o_tile_idx   (tile_idx),
    .o_err        (err)
`ifdef IBUF_SCHED_PERF_EN
    ,
    .o_stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   swaps = 0;
  int   swap_cyc = 0;
  int   done_cnt = 0;
  int   wait_cnt = 0;
  int   rd_len = 0;
  int   v_len = 0;
  bit   abort_flag = 1'b0;
  bit   beat_in_read = 1'b0;
  int   rows_q[$];
  int   v_q[$];
  job_t job_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Buffer model: o_dat_valid follows o_rd_en three cycles later.
  initial begin
    logic [2:0] sh;
    sh = '0;
    bus.i_dat_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.i_dat_valid = sh[2];
      @(negedge clk);
      sh = {sh[1:0], bus.o_rd_en};
    end
  end

  // Monitor: retires queued expectations as the DUT produces bursts and done pulses.
  initial begin
    logic rd_prev, v_prev, done_prev;
    job_t j;
    rd_prev = 1'b0; v_prev = 1'b0; done_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.o_bank_swap) begin
        check("swap_while_reading", {bus.o_rd_en, bus.i_dat_valid}, 0);
        swaps++;
        swap_cyc = cyc;
      end
      if (busy && swaps == 0 && !bus.o_bank_swap) wait_cnt++;
      if (bus.i_wr_beat && bus.o_rd_en) beat_in_read = 1'b1;
      if (bus.o_rd_en && !rd_prev) check("rd_after_swap", cyc - swap_cyc, 1);
      if (bus.o_rd_en) rd_len++;
      if (!bus.o_rd_en && rd_prev) begin
        if (!abort_flag) check("rd_len", rd_len, (rows_q.size() != 0) ? rows_q.pop_front() : -1);
        rd_len = 0;
      end
      if (bus.i_dat_valid) v_len++;
      if (!bus.i_dat_valid && v_prev) begin
        if (!abort_flag) check("valid_len", v_len, (v_q.size() != 0) ? v_q.pop_front() : -1);
        v_len = 0;
      end
      if (done) begin
        done_cnt++;
        check("done_width", done_prev, 0);
        if (job_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          j = job_q.pop_front();
          check("done_tile_idx", tile_idx, j.tiles);
          check("done_err", err, j.err);
          check("done_swaps", swaps, j.tiles);
          if (j.tiles > 0) check("tile_period", cyc - swap_cyc, j.rows + 5);
        end
      end
      rd_prev = bus.o_rd_en; v_prev = bus.i_dat_valid; done_prev = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  // Called and returning at posedge+1; start is sampled on the edge inside.
  task automatic start_job(input int tiles, input int r, input bit exp_err);
    job_t j;
    int   re;
    re = (r == 0) ? 1 : r;
    j.tiles = tiles; j.rows = re; j.err = exp_err;
    job_q.push_back(j);
    for (int t = 0; t < tiles; t++) begin
      rows_q.push_back(re);
      v_q.push_back(re);
    end
    swaps = 0; wait_cnt = 0; beat_in_read = 1'b0;
    start = 1'b1; num_tiles = TILE_W'(tiles); rows = (DEPTH_LOG2+1)'(r);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pkt(input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!bus.o_wr_allow && w < 400) begin
        @(posedge clk); #1;
        w++;
      end
      if (w >= 400) begin
        check("wr_allow_timeout", 0, 1);
        return;
      end
      bus.i_wr_beat = 1'b1;
      bus.i_wr_last = (i == n - 1);
      @(posedge clk); #1;
      bus.i_wr_beat = 1'b0;
      bus.i_wr_last = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    int w  = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && w < budget) begin
      @(posedge clk); #1;
      w++;
    end
    check(tag, done_cnt != d0, 1);
  endtask

  initial begin
    int   d0;
    logic bad;
    bus.i_wr_beat = 1'b0;
    bus.i_wr_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {busy, done, err, bus.o_wr_allow, bus.o_bank_swap, bus.o_rd_en}, 0);
    check("rst_tile_idx", tile_idx, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single tile, 4 rows, aligned packet.
    start_job(1, 4, 1'b0);
    send_pkt(3);
    wait_done(100, "t1_done");

    // Three tiles streamed back-to-back.
    d0 = done_cnt;
    start_job(3, 8, 1'b0);
    fork
      begin send_pkt(3); send_pkt(6); send_pkt(3); end
      wait_done(600, "t2_done");
    join
    repeat (10) @(posedge clk);
    #1;
    check("t2_fill_during_read", beat_in_read, 1);
    check("t2_done_once", done_cnt - d0, 1);

    // Misaligned packet sets the sticky error.
    start_job(1, 4, 1'b1);
    send_pkt(4);
    check("t3_err_set", err, 1);
    wait_done(100, "t3_done");

    // Abort together with start: abort wins, error is held.
    start = 1'b1; abort = 1'b1; num_tiles = TILE_W'(1);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start", busy, 0);
    check("err_held", err, 1);

    // Core not ready: bank stays full, no swap, writes gated.
    core_ready = 1'b0;
    start_job(1, 4, 1'b0);
    check("t4_err_cleared", err, 0);
    send_pkt(3);
    bad = 1'b0;
    repeat (20) begin
      bad |= bus.o_bank_swap | bus.o_wr_allow;
      @(posedge clk); #1;
    end
    check("t4_hold_no_swap", bad, 0);
    core_ready = 1'b1;
    wait_done(100, "t4_done");
`ifdef IBUF_SCHED_PERF_EN
    check("t4_stall_cycles", stall_cycles, wait_cnt);
`endif

    // Abort during READ, then a normal two-tile job.
    start_job(1, 16, 1'b0);
    send_pkt(3);
    d0 = 0;
    while (!bus.o_rd_en && d0 < 50) begin
      @(posedge clk); #1;
      d0++;
    end
    check("t5_rd_seen", bus.o_rd_en, 1);
    repeat (5) @(posedge clk);
    #1;
    abort_flag = 1'b1;
    abort = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t5_rd_dropped", bus.o_rd_en, 0);
    check("t5_busy_dropped", busy, 0);
    repeat (12) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt - d0, 0);
    job_q.delete(); rows_q.delete(); v_q.delete();
    abort_flag = 1'b0;
    start_job(2, 5, 1'b0);
    fork
      begin send_pkt(3); send_pkt(3); end
      wait_done(300, "t5_rerun_done");
    join

    // Zero tiles: immediate done, nothing else.
    start_job(0, 4, 1'b0);
    check("t6_done_pulse", done, 1);
    bad = 1'b0;
    repeat (5) begin
      bad |= bus.o_wr_allow | busy;
      @(posedge clk); #1;
    end
    check("t6_idle", bad, 0);
    check("t6_no_swap", swaps, 0);

    // Zero rows behaves as one row.
    start_job(1, 0, 1'b0);
    send_pkt(3);
    wait_done(100, "t7_done");

    repeat (5) @(posedge clk);
    #1;
    check("queues_drained", job_q.size() + rows_q.size() + v_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
